// File: rtl/rmt_pkg.sv
// Shared definitions for the RMT header filter and its destination demux.
// Holds the frame-state encoding and the func_type to tdest mapping.
package rmt_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_FWD  = 2'd1,
        STATE_DROP = 2'd2
    } state_t;

    localparam int unsigned DEST_DEFAULT = 0;
    localparam int unsigned DEST_FUNC1   = 1;

endpackage

// File: rtl/rmt_dest_demux_stats.sv
// Per-port forwarded-frame counters and a dropped-frame counter.
// Instantiated by rmt_dest_demux when RMT_DEMUX_STATS_EN is defined.
module rmt_dest_demux_stats #(
    parameter int M_COUNT   = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [M_COUNT-1:0]           fwd_last,
    input  logic                         drop_last,
    output logic [M_COUNT*CNT_WIDTH-1:0] fwd_frames,
    output logic [CNT_WIDTH-1:0]         drop_frames
);

    for (genvar p = 0; p < M_COUNT; p++) begin : g_fwd
        always_ff @(posedge clk) begin
            if (rst) begin
                fwd_frames[p*CNT_WIDTH +: CNT_WIDTH] <= '0;
            end else if (fwd_last[p]) begin
                fwd_frames[p*CNT_WIDTH +: CNT_WIDTH] <=
                    fwd_frames[p*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_frames <= '0;
        end else if (drop_last) begin
            drop_frames <= drop_frames + 1'b1;
        end
    end

endmodule

// File: rtl/rmt_dest_demux.sv
// Steers whole AXI-Stream frames to one of M_COUNT ports by first-beat tdest.
// Optional statistics counters enabled by defining RMT_DEMUX_STATS_EN.
module rmt_dest_demux
    import rmt_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int USER_WIDTH = 8,
    parameter int DEST_WIDTH = 2,
    parameter int M_COUNT    = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [USER_WIDTH-1:0]         s_axis_tuser,
    input  logic [DEST_WIDTH-1:0]         s_axis_tdest,
    output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [M_COUNT-1:0]            m_axis_tvalid,
    input  logic [M_COUNT-1:0]            m_axis_tready,
    output logic [M_COUNT-1:0]            m_axis_tlast,
    output logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser
`ifdef RMT_DEMUX_STATS_EN
    ,
    output logic [M_COUNT*CNT_WIDTH-1:0]  stat_fwd_frames,
    output logic [CNT_WIDTH-1:0]          stat_drop_frames
`endif
);

    localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [M_COUNT-1:0]    valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [KEEP_WIDTH-1:0] keep_q;
    logic [USER_WIDTH-1:0] user_q;
    logic                  last_q;

    logic in_range;
    logic unload;
    logic accept;
    logic load;
    logic drop_frame;

    // The held beat always belongs to sel_q, so its ready gates the input.
    assign unload   = (|valid_q) && m_axis_tready[sel_q];
    assign in_range = int'(s_axis_tdest) < M_COUNT;

    always_comb begin
        s_axis_tready = 1'b0;
        if (!rst) begin
            s_axis_tready = (state_q == STATE_DROP) || !(|valid_q) ||
                            m_axis_tready[sel_q];
        end
    end

    assign accept = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        load       = 1'b0;
        drop_frame = 1'b0;
        unique case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        load  = 1'b1;
                        sel_d = s_axis_tdest[SEL_W-1:0];
                        if (!s_axis_tlast) state_d = STATE_FWD;
                    end else if (s_axis_tlast) begin
                        drop_frame = 1'b1;
                    end else begin
                        state_d = STATE_DROP;
                    end
                end
            end
            STATE_FWD: begin
                if (accept) begin
                    load = 1'b1;
                    if (s_axis_tlast) state_d = STATE_IDLE;
                end
            end
            STATE_DROP: begin
                if (accept && s_axis_tlast) begin
                    state_d    = STATE_IDLE;
                    drop_frame = 1'b1;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (unload) valid_d = '0;
        if (load) begin
            valid_d        = '0;
            valid_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            sel_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= s_axis_tdata;
            keep_q <= s_axis_tkeep;
            user_q <= s_axis_tuser;
            last_q <= s_axis_tlast;
        end
    end

    assign m_axis_tvalid = valid_q;
    assign m_axis_tdata  = {M_COUNT{data_q}};
    assign m_axis_tkeep  = {M_COUNT{keep_q}};
    assign m_axis_tuser  = {M_COUNT{user_q}};
    assign m_axis_tlast  = {M_COUNT{last_q}};

`ifdef RMT_DEMUX_STATS_EN
    logic [M_COUNT-1:0] fwd_last;

    assign fwd_last = valid_q & m_axis_tready & {M_COUNT{last_q}};

    rmt_dest_demux_stats #(
        .M_COUNT   (M_COUNT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stats (
        .clk         (clk),
        .rst         (rst),
        .fwd_last    (fwd_last),
        .drop_last   (drop_frame),
        .fwd_frames  (stat_fwd_frames),
        .drop_frames (stat_drop_frames)
    );
`else
    logic unused_cfg;

    assign unused_cfg = drop_frame ^ (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_rmt_dest_demux.sv
// Directed bench for rmt_dest_demux: routing, tdest latching, drops,
// back-pressure, back-to-back frames and mid-frame reset.
module tb_rmt_dest_demux;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int UW = 8;
    localparam int MC = 2;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_tdata;
    logic [KW-1:0]   s_tkeep;
    logic            s_tvalid;
    logic            s_tready;
    logic            s_tlast;
    logic [UW-1:0]   s_tuser;
    logic [1:0]      s_tdest;
    logic [MC*DW-1:0] m_tdata;
    logic [MC*KW-1:0] m_tkeep;
    logic [MC-1:0]   m_tvalid;
    logic [MC-1:0]   m_tready;
    logic [MC-1:0]   m_tlast;
    logic [MC*UW-1:0] m_tuser;
`ifdef RMT_DEMUX_STATS_EN
    logic [MC*CW-1:0] stat_fwd;
    logic [CW-1:0]   stat_drop;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rmt_dest_demux #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .USER_WIDTH (UW),
        .DEST_WIDTH (2),
        .M_COUNT    (MC),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_tdata),
        .s_axis_tkeep     (s_tkeep),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .s_axis_tlast     (s_tlast),
        .s_axis_tuser     (s_tuser),
        .s_axis_tdest     (s_tdest),
        .m_axis_tdata     (m_tdata),
        .m_axis_tkeep     (m_tkeep),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tready    (m_tready),
        .m_axis_tlast     (m_tlast),
        .m_axis_tuser     (m_tuser)
`ifdef RMT_DEMUX_STATS_EN
        ,
        .stat_fwd_frames  (stat_fwd),
        .stat_drop_frames (stat_drop)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one input cycle, then check tready and the registered outputs.
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic l, input logic [1:0] dst,
                        input logic [MC-1:0] ev, input logic [DW-1:0] ed,
                        input logic el, input logic er);
        int p;
        s_tvalid = v;
        s_tdata  = d;
        s_tkeep  = d[KW-1:0];
        s_tuser  = d[7:0] ^ 8'h5a;
        s_tlast  = l;
        s_tdest  = dst;
        @(negedge clk);
        chk("s_tready", 64'(s_tready), 64'(er));
        chk("m_tvalid", 64'(m_tvalid), 64'(ev));
        if (ev != '0) begin
            p = ev[1] ? 1 : 0;
            chk("m_tdata", 64'(m_tdata[p*DW +: DW]), 64'(ed));
            chk("m_tkeep", 64'(m_tkeep[p*KW +: KW]), 64'(ed[KW-1:0]));
            chk("m_tuser", 64'(m_tuser[p*UW +: UW]), 64'(ed[7:0] ^ 8'h5a));
            chk("m_tlast", 64'(m_tlast[p]), 64'(el));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        s_tdest  = '0;
        m_tready = 2'b11;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 3-beat frame to port 1
        step(1, 32'hA1A1_0001, 0, 1, 2'b00, 0, 0, 1);
        step(1, 32'hA2A2_0002, 0, 1, 2'b10, 32'hA1A1_0001, 0, 1);
        step(1, 32'hA3A3_0003, 1, 1, 2'b10, 32'hA2A2_0002, 0, 1);
        step(0, 0, 0, 0, 2'b10, 32'hA3A3_0003, 1, 1);

        // tdest changes mid-frame; frame stays on port 1
        step(1, 32'hB1B1_0011, 0, 1, 2'b00, 0, 0, 1);
        step(1, 32'hB2B2_0012, 0, 0, 2'b10, 32'hB1B1_0011, 0, 1);
        step(1, 32'hB3B3_0013, 0, 0, 2'b10, 32'hB2B2_0012, 0, 1);
        step(1, 32'hB4B4_0014, 1, 0, 2'b10, 32'hB3B3_0013, 0, 1);
        step(1, 32'hC1C1_0021, 1, 0, 2'b10, 32'hB4B4_0014, 1, 1);
        step(0, 0, 0, 0, 2'b01, 32'hC1C1_0021, 1, 1);

        // port 0 stalls for 5 cycles mid-frame
        step(1, 32'hD1D1_0031, 0, 0, 2'b00, 0, 0, 1);
        step(1, 32'hD2D2_0032, 0, 0, 2'b01, 32'hD1D1_0031, 0, 1);
        m_tready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step(1, 32'hD3D3_0033, 1, 0, 2'b01, 32'hD2D2_0032, 0, 0);
        end
        m_tready = 2'b11;
        step(1, 32'hD3D3_0033, 1, 0, 2'b01, 32'hD2D2_0032, 0, 1);
        step(0, 0, 0, 0, 2'b01, 32'hD3D3_0033, 1, 1);
        step(0, 0, 0, 0, 2'b00, 0, 0, 1);

        // out-of-range tdest frames are swallowed, sinks not ready
        step(1, 32'hE1E1_0041, 0, 3, 2'b00, 0, 0, 1);
        m_tready = 2'b00;
        step(1, 32'hE2E2_0042, 1, 3, 2'b00, 0, 0, 1);
        m_tready = 2'b11;
        step(1, 32'hF1F1_0051, 1, 2, 2'b00, 0, 0, 1);
        step(0, 0, 0, 0, 2'b00, 0, 0, 1);
`ifdef RMT_DEMUX_STATS_EN
        chk("stat_drop", 64'(stat_drop), 64'd2);
`endif

        // back-to-back single-beat frames alternating ports
        step(1, 32'h6060_0060, 1, 0, 2'b00, 0, 0, 1);
        step(1, 32'h6161_0061, 1, 1, 2'b01, 32'h6060_0060, 1, 1);
        step(1, 32'h6262_0062, 1, 0, 2'b10, 32'h6161_0061, 1, 1);
        step(1, 32'h6363_0063, 1, 1, 2'b01, 32'h6262_0062, 1, 1);
        step(0, 0, 0, 0, 2'b10, 32'h6363_0063, 1, 1);
`ifdef RMT_DEMUX_STATS_EN
        chk("stat_fwd0", 64'(stat_fwd[0 +: CW]), 64'd4);
        chk("stat_fwd1", 64'(stat_fwd[CW +: CW]), 64'd4);
`endif

        // reset in the middle of a frame
        step(1, 32'h7171_0071, 0, 1, 2'b00, 0, 0, 1);
        step(1, 32'h7272_0072, 0, 1, 2'b10, 32'h7171_0071, 0, 1);
        rst      = 1'b1;
        s_tdata  = 32'h7373_0073;
        s_tkeep  = 4'h3;
        s_tdest  = 2'd1;
        @(negedge clk);
        chk("rst_mid_tready", 64'(s_tready), 64'd0);
        chk("rst_mid_tvalid", 64'(m_tvalid), 64'b10);
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef RMT_DEMUX_STATS_EN
        chk("rst_stat_drop", 64'(stat_drop), 64'd0);
        chk("rst_stat_fwd", 64'(stat_fwd), 64'd0);
`endif
        step(1, 32'h8181_0081, 1, 0, 2'b00, 0, 0, 1);
        step(0, 0, 0, 0, 2'b01, 32'h8181_0081, 1, 1);
        step(0, 0, 0, 0, 2'b00, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
